// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter and load scoreboard in front of the register file.
// ALU results always win the single registered write port; load responses wait
// in a small FIFO and drain whenever the ALU is idle. A busy bit per register
// tracks outstanding loads and drives the decode stall.
// Optional feature macro: WB_LQ_COUNT_EN (adds the lq_count occupancy port).
module wb_arbiter #(
  parameter int N        = 32,
  parameter int W        = 32,
  parameter int LQ_DEPTH = 2,
  localparam int A       = $clog2(N),
  localparam int PW      = $clog2(LQ_DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [A-1:0]  alu_rd,
  input  logic [W-1:0]  alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [A-1:0]  ld_rd,
  input  logic [W-1:0]  ld_data,
  input  logic          iss_load,
  input  logic [A-1:0]  iss_rd,
  input  logic [A-1:0]  dec_rs1,
  input  logic [A-1:0]  dec_rs2,
  input  logic [A-1:0]  dec_rd,
  output logic          stall,
  output logic          wen,
  output logic [A-1:0]  waddr,
  output logic [W-1:0]  wdata
`ifdef WB_LQ_COUNT_EN
  ,
  output logic [CW-1:0] lq_count
`endif
);

  // Load queue storage and bookkeeping; LQ_DEPTH is a power of two so the
  // pointers wrap naturally.
  logic [A-1:0]  lq_rd   [LQ_DEPTH];
  logic [W-1:0]  lq_data [LQ_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Item chosen for the write port this cycle.
  logic          sel_valid;
  logic          sel_load;
  logic [A-1:0]  sel_rd;
  logic [W-1:0]  sel_data;

  // The registered write currently on the port came from a load (to a nonzero rd).
  logic          wload;

  // One bit per architectural register with an outstanding load.
  logic [N-1:0]  busy;

  assign full     = (count == CW'(LQ_DEPTH));
  assign empty    = (count == '0);
  // ld_ready only looks at registered occupancy, so a same-cycle pop never
  // lets a new response in while the queue is full.
  assign ld_ready = !full && !rst;
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && !empty;

  // Queue storage: data is only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[tail]   <= ld_rd;
      lq_data[tail] <= ld_data;
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Priority select: ALU result first, otherwise the oldest queued load.
  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = lq_rd[head];
      sel_data  = lq_data[head];
    end
  end

  // Registered write port; writes to x0 are suppressed but a load to x0 is still consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      wload <= 1'b0;
    end else begin
      wen   <= sel_valid && (sel_rd != '0);
      waddr <= sel_rd;
      wdata <= sel_data;
      wload <= sel_load && (sel_rd != '0);
    end
  end

  // Scoreboard: set on load issue, cleared on the edge that commits the load's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wen && wload) begin
        busy[waddr] <= 1'b0;
      end
      if (iss_load && (iss_rd != '0)) begin
        busy[iss_rd] <= 1'b1;
      end
    end
  end

  // The dec_rd term blocks WAW hazards and a second issue to an already busy register.
  assign stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

`ifdef WB_LQ_COUNT_EN
  assign lq_count = count;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. A queue-based model predicts
// every write-port transaction plus ld_ready/stall per cycle; a negedge monitor
// pops those predictions and compares them against the DUT.
// Build with +define+WB_LQ_COUNT_EN to also compare lq_count.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int N        = 32;
  localparam int W        = 32;
  localparam int LQ_DEPTH = 2;
  localparam int A        = $clog2(N);
  localparam int CW       = $clog2(LQ_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [A-1:0]  alu_rd = '0;
  logic [W-1:0]  alu_data = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [A-1:0]  ld_rd = '0;
  logic [W-1:0]  ld_data = '0;
  logic          iss_load = 1'b0;
  logic [A-1:0]  iss_rd = '0;
  logic [A-1:0]  dec_rs1 = '0;
  logic [A-1:0]  dec_rs2 = '0;
  logic [A-1:0]  dec_rd = '0;
  logic          stall;
  logic          wen;
  logic [A-1:0]  waddr;
  logic [W-1:0]  wdata;
`ifdef WB_LQ_COUNT_EN
  logic [CW-1:0] lq_count;
`endif

  wb_arbiter #(.N(N), .W(W), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .iss_load  (iss_load),
    .iss_rd    (iss_rd),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .dec_rd    (dec_rd),
    .stall     (stall),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata)
`ifdef WB_LQ_COUNT_EN
    ,
    .lq_count  (lq_count)
`endif
  );

  typedef struct packed {
    logic         rst;
    logic         alu_valid;
    logic [A-1:0] alu_rd;
    logic [W-1:0] alu_data;
    logic         ld_valid;
    logic [A-1:0] ld_rd;
    logic [W-1:0] ld_data;
    logic         iss_load;
    logic [A-1:0] iss_rd;
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    logic [A-1:0] rd;
  } stim_t;

  typedef struct packed { int due; logic [A-1:0] rd; logic [W-1:0] data; } wr_t;
  typedef struct packed { int cyc; logic ready; logic stall; int count; logic chk_zero; } ctl_t;
  typedef struct packed { logic [A-1:0] rd; logic [W-1:0] data; } ld_t;
  typedef struct packed { int cyc; logic [A-1:0] rd; } clr_t;

  // Reference model state.
  ld_t          lq_m[$];
  bit           busy_m[N];
  clr_t         clr_q[$];
  wr_t          wr_q[$];
  ctl_t         ctl_q[$];
  logic [A-1:0] outstanding[$];
  bit           offer_pend = 1'b0;
  ld_t          offer;

  int  cyc = 0;
  int  checks = 0;
  int  passed = 0;
  bit  mon_en = 1'b0;
  ctl_t mon_c;
  wr_t  mon_w;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index: value k holds between posedge k and posedge k+1.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // Monitor: compare the DUT against the predictions due in this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) begin
        mon_c = ctl_q.pop_front();
        check_output("ld_ready", {63'd0, ld_ready}, {63'd0, mon_c.ready});
        check_output("stall", {63'd0, stall}, {63'd0, mon_c.stall});
`ifdef WB_LQ_COUNT_EN
        check_output("lq_count", {{(64-CW){1'b0}}, lq_count}, 64'(mon_c.count));
`endif
        if (mon_c.chk_zero) begin
          check_output("waddr_reset", {{(64-A){1'b0}}, waddr}, 64'd0);
          check_output("wdata_reset", {32'd0, wdata}, 64'd0);
        end
      end
      if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
        mon_w = wr_q.pop_front();
        check_output("wen", {63'd0, wen}, 64'd1);
        check_output("waddr", {{(64-A){1'b0}}, waddr}, {{(64-A){1'b0}}, mon_w.rd});
        check_output("wdata", {32'd0, wdata}, {32'd0, mon_w.data});
      end else begin
        check_output("wen_idle", {63'd0, wen}, 64'd0);
      end
    end
  end

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drive one cycle of inputs, predict its effects, and advance to the next cycle.
  task automatic apply_stimulus(input stim_t s, input bit chk_zero);
    bit   ready_e;
    bit   stall_e;
    ld_t  h;
    rst       = s.rst;
    alu_valid = s.alu_valid;
    alu_rd    = s.alu_rd;
    alu_data  = s.alu_data;
    ld_valid  = s.ld_valid;
    ld_rd     = s.ld_rd;
    ld_data   = s.ld_data;
    iss_load  = s.iss_load;
    iss_rd    = s.iss_rd;
    dec_rs1   = s.rs1;
    dec_rs2   = s.rs2;
    dec_rd    = s.rd;

    ready_e = !s.rst && (lq_m.size() < LQ_DEPTH);
    stall_e = busy_m[s.rs1] | busy_m[s.rs2] | busy_m[s.rd];
    ctl_q.push_back('{cyc, ready_e, stall_e, lq_m.size(), chk_zero});

    if (!s.rst) begin
      assert (!(s.alu_valid && busy_m[s.alu_rd]))
        else $error("[TB] illegal ALU write to busy register %0d", s.alu_rd);
      assert (!(s.iss_load && stall_e))
        else $error("[TB] illegal issue while stalled");
    end

    if (s.rst) begin
      while (wr_q.size() > 0 && wr_q[$].due > cyc) void'(wr_q.pop_back());
      lq_m.delete();
      clr_q.delete();
      outstanding.delete();
      offer_pend = 1'b0;
    end else begin
      if (s.alu_valid) begin
        if (s.alu_rd != '0) wr_q.push_back('{cyc + 1, s.alu_rd, s.alu_data});
      end else if (lq_m.size() > 0) begin
        h = lq_m.pop_front();
        if (h.rd != '0) begin
          wr_q.push_back('{cyc + 1, h.rd, h.data});
          clr_q.push_back('{cyc + 2, h.rd});
        end
      end
      if (s.ld_valid && ready_e) lq_m.push_back('{s.ld_rd, s.ld_data});
    end

    @(posedge clk);
    #1;
    if (s.rst) begin
      for (int i = 0; i < N; i++) busy_m[i] = 1'b0;
    end else if (s.iss_load && s.iss_rd != '0) begin
      busy_m[s.iss_rd] = 1'b1;
    end
    while (clr_q.size() > 0 && clr_q[0].cyc <= cyc) begin
      busy_m[clr_q[0].rd] = 1'b0;
      void'(clr_q.pop_front());
    end
  endtask

  task automatic idle_cycles(input int n, input logic [A-1:0] rs1);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = idle_stim();
      s.rs1 = rs1;
      apply_stimulus(s, 1'b0);
    end
  endtask

  task automatic issue(input logic [A-1:0] r);
    stim_t s;
    s = idle_stim();
    s.rd = r;
    s.iss_load = 1'b1;
    s.iss_rd = r;
    apply_stimulus(s, 1'b0);
  endtask

  task automatic alu_and_load(input bit av, input logic [A-1:0] ar, input logic [W-1:0] ad,
                              input bit lv, input logic [A-1:0] lr, input logic [W-1:0] lw,
                              input logic [A-1:0] rs1);
    stim_t s;
    s = idle_stim();
    s.alu_valid = av; s.alu_rd = ar; s.alu_data = ad;
    s.ld_valid = lv;  s.ld_rd = lr;  s.ld_data = lw;
    s.rs1 = rs1;
    apply_stimulus(s, 1'b0);
  endtask

  // Random legal traffic: loads only respond to issued destinations, ALU avoids busy registers.
  task automatic drive_random();
    stim_t s;
    bit    stall_now;
    int    k;
    logic [A-1:0] r;
    s = idle_stim();
    s.rst = ($urandom_range(0, 399) == 0);
    s.rs1 = A'($urandom_range(0, 7));
    s.rs2 = A'($urandom_range(0, 7));
    s.rd  = A'($urandom_range(0, 7));
    if (!s.rst) begin
      stall_now = busy_m[s.rs1] | busy_m[s.rs2] | busy_m[s.rd];
      if (!offer_pend && outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, outstanding.size() - 1);
        offer.rd = outstanding[k];
        offer.data = $urandom;
        outstanding.delete(k);
        offer_pend = 1'b1;
      end
      if (offer_pend) begin
        s.ld_valid = 1'b1;
        s.ld_rd = offer.rd;
        s.ld_data = offer.data;
        if (lq_m.size() < LQ_DEPTH) offer_pend = 1'b0;
      end
      if (!stall_now && outstanding.size() < 4 && $urandom_range(0, 2) == 0) begin
        s.iss_load = 1'b1;
        s.iss_rd = s.rd;
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 8; t++) begin
          r = A'($urandom_range(0, 7));
          if (!busy_m[r] && !(s.iss_load && r == s.iss_rd && r != '0)) begin
            s.alu_valid = 1'b1;
            s.alu_rd = r;
            s.alu_data = $urandom;
            break;
          end
        end
      end
      if (s.iss_load) outstanding.push_back(s.iss_rd);
    end
    apply_stimulus(s, 1'b0);
  endtask

  // Main sequence: directed scenarios followed by randomized traffic.
  initial begin
    stim_t s;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held, then idle with reset values checked.
    s = idle_stim();
    s.rst = 1'b1;
    apply_stimulus(s, 1'b0);
    apply_stimulus(idle_stim(), 1'b1);
    idle_cycles(1, '0);

    // ALU write to x5, then the same write to x0.
    alu_and_load(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    idle_cycles(1, '0);
    alu_and_load(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    idle_cycles(1, '0);

    // Load to x7 with a dependent decode.
    issue(5'd7);
    idle_cycles(3, 5'd7);
    alu_and_load(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_1234, 5'd7);
    idle_cycles(5, 5'd7);

    // Queue fills while the ALU holds the port for three cycles.
    issue(5'd3);
    issue(5'd4);
    alu_and_load(1'b1, 5'd10, 32'hA0A0_0010, 1'b1, 5'd3, 32'h3333_0003, '0);
    alu_and_load(1'b1, 5'd11, 32'hA0A0_0011, 1'b1, 5'd4, 32'h4444_0004, '0);
    alu_and_load(1'b1, 5'd12, 32'hA0A0_0012, 1'b0, '0, '0, '0);
    idle_cycles(5, '0);

    // Push and pop together at occupancy 1.
    issue(5'd13);
    issue(5'd14);
    alu_and_load(1'b1, 5'd15, 32'hB0B0_0015, 1'b1, 5'd13, 32'hD00D_0013, '0);
    alu_and_load(1'b0, '0, '0, 1'b1, 5'd14, 32'hD00D_0014, '0);
    idle_cycles(4, '0);

    // Reset with two queued loads and x9 busy.
    issue(5'd9);
    issue(5'd11);
    alu_and_load(1'b1, 5'd16, 32'hC0C0_0016, 1'b1, 5'd9, 32'h9999_0009, 5'd9);
    alu_and_load(1'b1, 5'd17, 32'hC0C0_0017, 1'b1, 5'd11, 32'hBBBB_000B, 5'd9);
    s = idle_stim();
    s.rst = 1'b1;
    s.rs1 = 5'd9;
    apply_stimulus(s, 1'b0);
    idle_cycles(4, 5'd9);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) drive_random();
    idle_cycles(10, '0);

    check_output("writes_drained", 64'(wr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
